// File: rtl/str_sender_pkg.sv
// ---------------------------------------------------------------------------
// str_sender_pkg
// Shared definitions for the string sender: string IDs used by the mode
// subsystems, ASCII line terminators, ROM sizing and the sender FSM states.
// ---------------------------------------------------------------------------
package str_sender_pkg;

    localparam int STR_MAX_LEN = 10;
    localparam int NUM_STR     = 8;
    localparam int STR_ID_W    = $clog2(NUM_STR);
    localparam int IDX_W       = $clog2(STR_MAX_LEN + 1);
    localparam int STR_W       = 8 * STR_MAX_LEN;

    typedef logic [IDX_W-1:0] idx_t;

    localparam logic [2:0] STR_ID_WELCOME = 3'd0;
    localparam logic [2:0] STR_ID_MODE_IN = 3'd1;
    localparam logic [2:0] STR_ID_GEN     = 3'd2;
    localparam logic [2:0] STR_ID_SHOW    = 3'd3;
    localparam logic [2:0] STR_ID_SET     = 3'd4;
    localparam logic [2:0] STR_ID_CALC    = 3'd5;
    localparam logic [2:0] STR_ID_ERROR   = 3'd6;
    localparam logic [2:0] STR_ID_DONE    = 3'd7;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_BODY,
        ST_SEND_CR,
        ST_SEND_LF,
        ST_DONE
    } state_e;

endpackage

// File: rtl/str_sender_rom.sv
// ---------------------------------------------------------------------------
// str_sender_rom
// Combinational string table: (id, idx) -> character, id -> body length.
// Bodies are stored right-aligned in a packed vector (first character in the
// most significant occupied byte), so character idx of a length-L string
// sits at byte position L-1-idx.
//
// Ports:
//   id_i    string ID
//   idx_i   character index within the body
//   char_o  character at idx_i (0x00 when idx_i >= length)
//   len_o   body length of string id_i, excluding CR LF
// ---------------------------------------------------------------------------
module str_sender_rom
    import str_sender_pkg::*;
(
    input  logic [STR_ID_W-1:0] id_i,
    input  idx_t                idx_i,
    output logic [7:0]          char_o,
    output idx_t                len_o
);

    logic [STR_W-1:0] body;
    logic [STR_W-1:0] shifted;
    int               shift;

    always_comb begin
        body  = '0;
        len_o = '0;
        case (id_i)
            STR_ID_WELCOME: begin body = STR_W'("welcome");   len_o = idx_t'(7); end
            STR_ID_MODE_IN: begin body = STR_W'("mode-in");   len_o = idx_t'(7); end
            STR_ID_GEN:     begin body = STR_W'("mode-gen");  len_o = idx_t'(8); end
            STR_ID_SHOW:    begin body = STR_W'("mode-show"); len_o = idx_t'(9); end
            STR_ID_SET:     begin body = STR_W'("mode-set");  len_o = idx_t'(8); end
            STR_ID_CALC:    begin body = STR_W'("mode-calc"); len_o = idx_t'(9); end
            STR_ID_ERROR:   begin body = STR_W'("error");     len_o = idx_t'(5); end
            STR_ID_DONE:    begin body = STR_W'("done");      len_o = idx_t'(4); end
            default:        begin body = '0;                  len_o = '0;        end
        endcase
    end

    always_comb begin
        shift   = 8 * (int'(len_o) - 1 - int'(idx_i));
        shifted = '0;
        char_o  = 8'h00;
        if (idx_i < len_o) begin
            shifted = body >> shift;
            char_o  = shifted[7:0];
        end
    end

endmodule

// File: rtl/str_sender.sv
// ---------------------------------------------------------------------------
// str_sender
// Responder for the sender_str string-request protocol. A one-cycle request
// latches a string ID; the body bytes followed by CR LF are streamed over a
// valid/ready byte interface to the UART transmitter, then sender_done pulses
// for one cycle before the block becomes ready again.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | ready for a request, no traffic
// ST_SEND_BODY | presenting body byte idx_q of the latched string
// ST_SEND_CR   | presenting 0x0D
// ST_SEND_LF   | presenting 0x0A
// ST_DONE      | one-cycle sender_done pulse, still not ready
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   sender_str      one-cycle request strobe (honoured only in ST_IDLE)
//   sender_str_id   string ID, sampled with sender_str
//   sender_ready    high only in ST_IDLE
//   sender_done     one-cycle pulse after LF has been handed off
//   tx_data/tx_valid/tx_ready  byte stream to uart_tx
// ---------------------------------------------------------------------------
module str_sender
    import str_sender_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sender_str,
    input  logic [STR_ID_W-1:0] sender_str_id,
    output logic                sender_ready,
    output logic                sender_done,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready
);

    state_e              state_q, state_d;
    idx_t                idx_q,   idx_d;
    logic [STR_ID_W-1:0] id_q,    id_d;

    logic [STR_ID_W-1:0] rom_id;
    logic [7:0]          rom_char;
    idx_t                rom_len;
    logic                xfer;

    // In IDLE the ROM looks at the incoming ID so a zero-length body can
    // skip straight to CR on the request edge.
    assign rom_id = (state_q == ST_IDLE) ? sender_str_id : id_q;

    str_sender_rom u_rom (
        .id_i   (rom_id),
        .idx_i  (idx_q),
        .char_o (rom_char),
        .len_o  (rom_len)
    );

    assign xfer = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        id_d         = id_q;
        sender_ready = 1'b0;
        sender_done  = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;

        case (state_q)
            ST_IDLE: begin
                sender_ready = 1'b1;
                if (sender_str) begin
                    id_d    = sender_str_id;
                    idx_d   = '0;
                    state_d = (rom_len == '0) ? ST_SEND_CR : ST_SEND_BODY;
                end
            end
            ST_SEND_BODY: begin
                tx_valid = 1'b1;
                tx_data  = rom_char;
                if (xfer) begin
                    // Hold idx at len-1 on the last byte so it never runs
                    // past the body.
                    if (idx_q == rom_len - idx_t'(1)) begin
                        state_d = ST_SEND_CR;
                    end else begin
                        idx_d = idx_q + idx_t'(1);
                    end
                end
            end
            ST_SEND_CR: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_CR;
                if (xfer) state_d = ST_SEND_LF;
            end
            ST_SEND_LF: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_LF;
                if (xfer) state_d = ST_DONE;
            end
            ST_DONE: begin
                sender_done = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
